// File: rtl/btn_debounce_array.sv
// Multi-channel button front end: 2-flop sync, counter debounce, press/release
// pulses. Define BTN_AUTOREPEAT_EN to add the per-channel hold/auto-repeat FSM.
module btn_debounce_array #(
  parameter int NUM_BTN      = 2,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int HOLD_CYC     = 50_000_000,
  parameter int REPEAT_CYC   = 10_000_000
) (
  input  logic               clk_100,
  input  logic               a_rst_n,
  input  logic               s_rst,
  input  logic [NUM_BTN-1:0] btn_i,
  output logic [NUM_BTN-1:0] level_o,
  output logic [NUM_BTN-1:0] press_o,
  output logic [NUM_BTN-1:0] release_o,
  output logic [NUM_BTN-1:0] hold_o
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYC - 1);

`ifdef BTN_AUTOREPEAT_EN
  localparam int HMAX =
    (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int HW = $clog2(HMAX + 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYC - 1);
  localparam logic [HW-1:0] R_LAST = HW'(REPEAT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_HOLD,
    REPEAT
  } rpt_e;
`endif

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    logic          meta_q;
    logic          sync_q;
    logic [DW-1:0] dcnt_q;
    logic [DW-1:0] dcnt_d;
    logic          level_q;
    logic          level_d;
    logic          press_q;
    logic          press_d;
    logic          rel_q;
    logic          rel_d;
    logic          rise;
    logic          fall;

    // A mismatch must survive DEBOUNCE_CYC consecutive cycles to flip level.
    always_comb begin
      dcnt_d  = '0;
      level_d = level_q;
      if (sync_q != level_q) begin
        if (dcnt_q == D_LAST) begin
          level_d = ~level_q;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
    end

    assign rise  = level_d & ~level_q;
    assign fall  = ~level_d & level_q;
    assign rel_d = fall;

`ifdef BTN_AUTOREPEAT_EN
    rpt_e          st_q;
    rpt_e          st_d;
    logic [HW-1:0] hcnt_q;
    logic [HW-1:0] hcnt_d;
    logic          hold_q;
    logic          hold_d;
    logic          rpt;

    // A fall outranks a terminal count landing on the same edge.
    always_comb begin
      st_d   = st_q;
      hcnt_d = hcnt_q;
      hold_d = hold_q;
      rpt    = 1'b0;
      if (fall) begin
        st_d   = IDLE;
        hcnt_d = '0;
        hold_d = 1'b0;
      end else if (rise) begin
        st_d   = WAIT_HOLD;
        hcnt_d = '0;
      end else if (st_q == WAIT_HOLD) begin
        if (hcnt_q == H_LAST) begin
          rpt    = 1'b1;
          hold_d = 1'b1;
          hcnt_d = '0;
          st_d   = REPEAT;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end else if (st_q == REPEAT) begin
        if (hcnt_q == R_LAST) begin
          rpt    = 1'b1;
          hcnt_d = '0;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
    end

    assign press_d = rise | rpt;

    always_ff @(posedge clk_100 or negedge a_rst_n) begin
      if (!a_rst_n) begin
        st_q   <= IDLE;
        hcnt_q <= '0;
        hold_q <= 1'b0;
      end else if (s_rst) begin
        st_q   <= IDLE;
        hcnt_q <= '0;
        hold_q <= 1'b0;
      end else begin
        st_q   <= st_d;
        hcnt_q <= hcnt_d;
        hold_q <= hold_d;
      end
    end

    assign hold_o[i] = hold_q;
`else
    assign press_d   = rise;
    assign hold_o[i] = 1'b0;
`endif

    always_ff @(posedge clk_100 or negedge a_rst_n) begin
      if (!a_rst_n) begin
        meta_q  <= 1'b0;
        sync_q  <= 1'b0;
        dcnt_q  <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else if (s_rst) begin
        meta_q  <= 1'b0;
        sync_q  <= 1'b0;
        dcnt_q  <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        meta_q  <= btn_i[i];
        sync_q  <= meta_q;
        dcnt_q  <= dcnt_d;
        level_q <= level_d;
        press_q <= press_d;
        rel_q   <= rel_d;
      end
    end

    assign level_o[i]   = level_q;
    assign press_o[i]   = press_q;
    assign release_o[i] = rel_q;
  end

endmodule

// File: tb/tb_btn_debounce_array.sv
// Bench for btn_debounce_array: sample-window model checked every cycle,
// plus directed scenarios with literal pulse timings.
module tb_btn_debounce_array;

  localparam int NB = 2;
  localparam int DC = 4;
  localparam int HC = 20;
  localparam int RC = 8;

  logic          clk_100 = 1'b0;
  logic          a_rst_n = 1'b0;
  logic          s_rst   = 1'b0;
  logic [NB-1:0] btn_i   = '0;
  logic [NB-1:0] level_o;
  logic [NB-1:0] press_o;
  logic [NB-1:0] release_o;
  logic [NB-1:0] hold_o;

  int n_cmp = 0;
  int n_bad = 0;
  int ecnt  = 0;

  int pq0[$];
  int pq1[$];
  int rq0[$];
  int rq1[$];
  int hq[$];
  logic hp = 1'b0;

  always #5 clk_100 = ~clk_100;

  btn_debounce_array #(
    .NUM_BTN     (NB),
    .DEBOUNCE_CYC(DC),
    .HOLD_CYC    (HC),
    .REPEAT_CYC  (RC)
  ) dut (
    .clk_100  (clk_100),
    .a_rst_n  (a_rst_n),
    .s_rst    (s_rst),
    .btn_i    (btn_i),
    .level_o  (level_o),
    .press_o  (press_o),
    .release_o(release_o),
    .hold_o   (hold_o)
  );

  always @(posedge clk_100) ecnt <= ecnt + 1;

  // Model: level flips when the last DC synchronised samples (raw samples
  // taken 2..DC+1 edges ago) all disagree with it; repeats by press age.
  logic [DC+1:0] hist [NB];
  int            age  [NB];
  logic [NB-1:0] m_lvl;
  logic [NB-1:0] m_prs;
  logic [NB-1:0] m_rel;
  logic [NB-1:0] m_hld;

  always @(posedge clk_100 or negedge a_rst_n) begin : p_model
    logic [DC-1:0] win;
    logic          flip;
    if (!a_rst_n || s_rst) begin
      for (int c = 0; c < NB; c++) begin
        hist[c] = '0;
        age[c]  = 0;
      end
      m_lvl = '0;
      m_prs = '0;
      m_rel = '0;
      m_hld = '0;
    end else begin
      for (int c = 0; c < NB; c++) begin
        hist[c]  = {hist[c][DC:0], btn_i[c]};
        win      = hist[c][DC+1:2];
        flip     = m_lvl[c] ? (win == '0) : (win == '1);
        m_prs[c] = 1'b0;
        m_rel[c] = 1'b0;
        if (flip) begin
          m_lvl[c] = ~m_lvl[c];
          if (m_lvl[c]) begin
            m_prs[c] = 1'b1;
            age[c]   = 0;
          end else begin
            m_rel[c] = 1'b1;
            m_hld[c] = 1'b0;
          end
        end else if (m_lvl[c]) begin
`ifdef BTN_AUTOREPEAT_EN
          age[c] = age[c] + 1;
          if (age[c] == HC ||
              (age[c] > HC && (age[c] - HC) % RC == 0))
            m_prs[c] = 1'b1;
          m_hld[c] = (age[c] >= HC);
`endif
        end
      end
    end
  end

  always @(negedge clk_100) begin
    n_cmp++;
    if ({level_o, press_o, release_o, hold_o} !==
        {m_lvl, m_prs, m_rel, m_hld}) begin
      n_bad++;
      $display("FAIL outputs edge %0d: got lvl=%b prs=%b rel=%b hld=%b expected lvl=%b prs=%b rel=%b hld=%b",
               ecnt, level_o, press_o, release_o, hold_o,
               m_lvl, m_prs, m_rel, m_hld);
    end
    if (press_o[0] === 1'b1) pq0.push_back(ecnt);
    if (press_o[1] === 1'b1) pq1.push_back(ecnt);
    if (release_o[0] === 1'b1) rq0.push_back(ecnt);
    if (release_o[1] === 1'b1) rq1.push_back(ecnt);
    if (hold_o[0] === 1'b1 && !hp) hq.push_back(ecnt);
    hp = (hold_o[0] === 1'b1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -999;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_100);
      #1;
    end
  endtask

  task automatic clrq();
    pq0.delete();
    pq1.delete();
    rq0.delete();
    rq1.delete();
    hq.delete();
  endtask

  initial begin
    int t0;
    int t1;
    int lp;
    int l2;
`ifdef BTN_AUTOREPEAT_EN
    int offs[6] = '{0, 20, 28, 36, 44, 52};
    int offs2[5] = '{0, 20, 31, 51, 59};
`endif

    // Reset held with both buttons down
    btn_i = 2'b11;
    step(3);
    chk("rst_level", int'(level_o), 0);
    chk("rst_press", int'(press_o), 0);
    chk("rst_release", int'(release_o), 0);
    chk("rst_hold", int'(hold_o), 0);
    clrq();
    t0 = ecnt;
    a_rst_n = 1'b1;
    step(10);
    chk("rst_p0_cnt", pq0.size(), 1);
    chk("rst_p0_lat", qget(pq0, 0) - t0, 6);
    chk("rst_p1_lat", qget(pq1, 0) - t0, 6);
    t1 = ecnt;
    btn_i = 2'b00;
    step(10);
    chk("rst_r0_lat", qget(rq0, 0) - t1, 6);
    chk("rst_r1_lat", qget(rq1, 0) - t1, 6);

    // Clean press / release on channel 0
    clrq();
    t0 = ecnt;
    btn_i[0] = 1'b1;
    step(10);
    t1 = ecnt;
    btn_i[0] = 1'b0;
    step(10);
    chk("clean_p0_cnt", pq0.size(), 1);
    chk("clean_p0_lat", qget(pq0, 0) - t0, 6);
    chk("clean_r0_cnt", rq0.size(), 1);
    chk("clean_r0_lat", qget(rq0, 0) - t1, 6);
    chk("clean_p1_cnt", pq1.size(), 0);
    chk("clean_r1_cnt", rq1.size(), 0);

    // Bounce on channel 1, then a real press
    clrq();
    btn_i[1] = 1'b1;
    step(3);
    btn_i[1] = 1'b0;
    step(1);
    btn_i[1] = 1'b1;
    step(3);
    btn_i[1] = 1'b0;
    step(8);
    chk("bounce_p1_cnt", pq1.size(), 0);
    chk("bounce_r1_cnt", rq1.size(), 0);
    chk("bounce_lvl1", int'(level_o[1]), 0);
    t0 = ecnt;
    btn_i[1] = 1'b1;
    step(8);
    chk("bounce_hold_p1_cnt", pq1.size(), 1);
    chk("bounce_hold_p1_lat", qget(pq1, 0) - t0, 6);
    btn_i[1] = 1'b0;
    step(10);

    // Simultaneous press, release of bit 0 only
    clrq();
    t0 = ecnt;
    btn_i = 2'b11;
    step(10);
    chk("sim_p0_lat", qget(pq0, 0) - t0, 6);
    chk("sim_p1_lat", qget(pq1, 0) - t0, 6);
    btn_i = 2'b10;
    step(10);
    chk("sim_r0_cnt", rq0.size(), 1);
    chk("sim_r1_cnt", rq1.size(), 0);
    btn_i = 2'b00;
    step(10);

    // Long hold on channel 0
    clrq();
    t0 = ecnt;
    lp = t0 + 6;
    btn_i[0] = 1'b1;
    step(60);
    btn_i[0] = 1'b0;
    step(12);
    chk("ar_r0_at", qget(rq0, 0) - lp, 60);
`ifdef BTN_AUTOREPEAT_EN
    chk("ar_p0_cnt", pq0.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("ar_p0_%0d", i), qget(pq0, i) - lp, offs[i]);
    chk("ar_hold_cnt", hq.size(), 1);
    chk("ar_hold_rise", qget(hq, 0) - lp, 20);
`else
    chk("ar_p0_cnt", pq0.size(), 1);
    chk("ar_p0_0", qget(pq0, 0) - lp, 0);
    chk("ar_hold_cnt", hq.size(), 0);
`endif

    // Synchronous reset mid-hold
    clrq();
    t0 = ecnt;
    lp = t0 + 6;
    btn_i[0] = 1'b1;
    step(lp + 24 - ecnt);
    s_rst = 1'b1;
    step(1);
    s_rst = 1'b0;
    chk("srst_level", int'(level_o), 0);
    chk("srst_hold", int'(hold_o), 0);
    l2 = lp + 31;
    step(l2 + 30 - ecnt);
    btn_i[0] = 1'b0;
    step(12);
`ifdef BTN_AUTOREPEAT_EN
    chk("srst_p0_cnt", pq0.size(), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("srst_p0_%0d", i), qget(pq0, i) - lp, offs2[i]);
    chk("srst_hold_cnt", hq.size(), 2);
    chk("srst_hold_rise2", qget(hq, 1) - l2, 20);
`else
    chk("srst_p0_cnt", pq0.size(), 2);
    chk("srst_p0_1", qget(pq0, 1) - lp, 31);
`endif
    chk("srst_r0_at", qget(rq0, 0) - l2, 36);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/btn_debounce_array.md
# btn_debounce_array

Parametrised, multi-channel push-button front end for the SPI test harness, built as the successor to the two-button edge handler. Each of `NUM_BTN` asynchronous button inputs gets a double-flop synchroniser, a counter-based debouncer, and registered press/release pulses. An optional auto-repeat generator emits repeated press pulses while a button is held. Outputs feed the count-advance and send-start control logic.

## Interface
- `NUM_BTN`, default 2: number of independent button channels, ≥1.
- `DEBOUNCE_CYC`, default 1_000_000: consecutive synchronised cycles a new level must persist before it is accepted, ≥1.
- `HOLD_CYC`, default 50_000_000: cycles of debounced-high before the first repeat pulse, ≥1 (auto-repeat only).
- `REPEAT_CYC`, default 10_000_000: cycles between subsequent repeat pulses, ≥1 (auto-repeat only).

- `clk_100` input 1: system clock; all logic is on the rising edge.
- `a_rst_n` input 1: asynchronous reset, active-low.
- `s_rst` input 1: synchronous reset, active-high; same effect as `a_rst_n`.
- `btn_i` input NUM_BTN: raw, asynchronous, bouncing button levels, active-high.
- `level_o` output NUM_BTN: debounced level per channel.
- `press_o` output NUM_BTN: one-cycle pulse on an accepted rise, or on an auto-repeat.
- `release_o` output NUM_BTN: one-cycle pulse on an accepted fall.
- `hold_o` output NUM_BTN: high from a channel's first repeat pulse until its release.

## Operation
- Channels are fully independent. Any combination of bits may pulse in the same cycle.
- Reset (either source) clears all synchroniser flops, counters, `level_o`, `press_o`, `release_o` and `hold_o` to 0.
- Synchroniser: two flops per channel. `sync` is the second-flop output.
- Debouncer, per channel, with counter `dcnt` of width `$clog2(DEBOUNCE_CYC+1)`:
  - If `sync == level`, `dcnt` is cleared to 0.
  - Else, if `dcnt == DEBOUNCE_CYC-1`, `level` toggles and `dcnt` is cleared to 0.
  - Else, `dcnt` increments.
  - Any mismatch run shorter than `DEBOUNCE_CYC` cycles is discarded.
- Pulses:
  - `press_o` and `level_o` rise on the same edge.
  - `release_o` is high on the edge where `level_o` falls.
  - All outputs are registered; there is no combinational path from input to output.
- Auto-repeat (macro enabled), with counter `hcnt` of width `$clog2(max(HOLD_CYC,REPEAT_CYC)+1)`:
  - Per-channel states: IDLE, WAIT_HOLD, REPEAT.
  - IDLE → WAIT_HOLD on `level` rise; `hcnt` is cleared.
  - WAIT_HOLD: `hcnt` increments. When `hcnt == HOLD_CYC-1`, the block pulses `press_o`, sets `hold_o`, clears `hcnt` and goes to REPEAT.
  - REPEAT: `hcnt` increments. When `hcnt == REPEAT_CYC-1`, the block pulses `press_o` and clears `hcnt`.
  - On `level` fall, from any state: go to IDLE, clear `hold_o` and `hcnt`, and pulse `release_o`.
- Reset mid-operation:
  - All state is lost immediately.
  - A button still held after reset deasserts is treated as a new press: full debounce, then a `press_o` pulse.
- Counters never wrap. Each is cleared at its terminal value.

## Timing
- Press latency:
  - `btn_i` is first sampled high at edge 0 and stays stable.
  - `sync` goes high after edge 1.
  - `level_o` and `press_o` assert after edge `DEBOUNCE_CYC+1`.
  - `press_o` deasserts after the next edge.
- Release latency is symmetric: `DEBOUNCE_CYC+2` edges.
- Repeat pulses, with the first press at edge L:
  - Pulses occur at L+HOLD_CYC, L+HOLD_CYC+REPEAT_CYC, L+HOLD_CYC+2·REPEAT_CYC, …
  - `hold_o` rises with the first repeat pulse.
- `a_rst_n` forces outputs low asynchronously.
- Reset deassertion is synchronised externally. Logic resumes on the first edge with `a_rst_n` high and `s_rst` low.

## Configuration
- `BTN_AUTOREPEAT_EN`:
  - Defined: the auto-repeat FSM and `hcnt` are instantiated per channel, as described above.
  - Undefined: no FSM and no `hcnt` are instantiated. `press_o` pulses only on debounced rises. `hold_o` is tied to 0. `HOLD_CYC` and `REPEAT_CYC` are ignored.

## Test plan
All scenarios use `NUM_BTN`=2, `DEBOUNCE_CYC`=4, `HOLD_CYC`=20, `REPEAT_CYC`=8.

- **Reset:** hold `a_rst_n`=0 with `btn_i`=2'b11 → all outputs 0. Release reset → `level_o`=2'b11 and `press_o`=2'b11 for one cycle, 6 edges after release.
- **Clean press/release:** `btn_i[0]` rises, held 10 cycles, then falls → `press_o[0]` one pulse 6 edges after the rise. `release_o[0]` one pulse 6 edges after the fall. Channel 1 stays silent.
- **Bounce rejection:** `btn_i[1]` high 3 cycles, low 1, high 3, low → no `press_o`/`release_o`, `level_o[1]` stays 0. Then hold 5+ cycles → exactly one press.
- **Simultaneous:** both bits rise on the same edge → `press_o`=2'b11 in a single cycle. Release bit 0 only → `release_o`=2'b01.
- **Auto-repeat (macro defined):** hold `btn_i[0]` for 60 cycles → `press_o[0]` pulses at L, L+20, L+28, L+36, L+44, L+52. `hold_o[0]` rises at L+20 and clears with `release_o[0]`. With the macro undefined → only the pulse at L, and `hold_o`=0.
- **s_rst mid-hold:** assert `s_rst` one cycle at L+25 while held → outputs clear. Re-press follows after 6 edges, with repeats re-timed from the new L.
